// File: rtl/conv_filter_sched_if.sv
// Handshake and ROM/core bus between the sliding-window stage, the weight/bias
// ROMs, the conv core and the filter scheduler.
interface conv_filter_sched_if #(
    parameter int DATA_WIDTH        = 8,
    parameter int WADDR_WIDTH       = 9,
    parameter int FILTER_ADDR_WIDTH = 5
);
    logic                         win_valid;
    logic                         win_ready;
    logic                         win_latch;
    logic [WADDR_WIDTH-1:0]       w_addr;
    logic [DATA_WIDTH-1:0]        w_q;
    logic [FILTER_ADDR_WIDTH-1:0] b_addr;
    logic [9*DATA_WIDTH-1:0]      kw_flat;
    logic                         core_valid;
    logic [FILTER_ADDR_WIDTH-1:0] filter_idx;
    logic                         busy;
    logic                         patch_done;
    logic [15:0]                  patch_cnt;

    modport master (
        input  win_valid, w_q,
        output win_ready, win_latch, w_addr, b_addr, kw_flat,
               core_valid, filter_idx, busy, patch_done, patch_cnt
    );

    modport slave (
        output win_valid, w_q,
        input  win_ready, win_latch, w_addr, b_addr, kw_flat,
               core_valid, filter_idx, busy, patch_done, patch_cnt
    );
endinterface

// File: rtl/conv_filter_sched.sv
// Filter sequencer for the time-multiplexed 3x3 conv core: per accepted window it
// streams each filter's 9 weights from the weight ROM into a tap bank and fires the core.
module conv_filter_sched #(
    parameter int DATA_WIDTH        = 8,
    parameter int NUM_FILTERS       = 32,
    parameter int TAPS              = 9,
    parameter int WADDR_WIDTH       = 9,
    parameter int FILTER_ADDR_WIDTH = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    parameter int ROM_LATENCY       = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    conv_filter_sched_if.master     bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    localparam logic [3:0] LAT_STEP   = 4'(ROM_LATENCY);
    localparam logic [3:0] ISSUE_LAST = 4'(TAPS - 1);
    localparam logic [3:0] LAST_STEP  = 4'(ROM_LATENCY + TAPS - 1);
    localparam logic [FILTER_ADDR_WIDTH-1:0] FILT_LAST = FILTER_ADDR_WIDTH'(NUM_FILTERS - 1);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         w_ready;
    logic                         w_accept;
    logic                         w_fire;
    logic                         w_last;
    logic [3:0]                   w_cap_idx;
    logic [3:0]                   r_step;
    logic [WADDR_WIDTH-1:0]       r_w_addr;
    logic [WADDR_WIDTH-1:0]       r_base;
    logic [FILTER_ADDR_WIDTH-1:0] r_b_addr;
    logic [FILTER_ADDR_WIDTH-1:0] r_filter_idx;
    logic [15:0]                  r_patch_cnt;
    logic [DATA_WIDTH-1:0]        r_taps [TAPS];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_fire      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = ~i_rst;
                if (bus.win_valid && !i_rst) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (r_step == LAST_STEP) begin
                    w_state_nxt = ST_FIRE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FIRE: begin
                w_fire = 1'b1;
                w_last = (r_filter_idx == FILT_LAST);
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept  = bus.win_valid & w_ready;
    // ROM data returning now was addressed ROM_LATENCY fetch steps ago.
    assign w_cap_idx = r_step - LAT_STEP;

    // Address issue, tap capture and filter/patch counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_step       <= 4'd0;
            r_w_addr     <= '0;
            r_base       <= '0;
            r_b_addr     <= '0;
            r_filter_idx <= '0;
            r_patch_cnt  <= 16'd0;
            for (int i = 0; i < TAPS; i++) begin
                r_taps[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_step       <= 4'd0;
                        r_w_addr     <= '0;
                        r_base       <= '0;
                        r_b_addr     <= '0;
                        r_filter_idx <= '0;
                    end
                end
                ST_FETCH: begin
                    if (r_step < ISSUE_LAST) begin
                        r_w_addr <= r_w_addr + WADDR_WIDTH'(1);
                    end
                    if (r_step >= LAT_STEP) begin
                        r_taps[w_cap_idx] <= bus.w_q;
                    end
                    r_step <= r_step + 4'd1;
                end
                ST_FIRE: begin
                    r_step <= 4'd0;
                    if (w_last) begin
                        r_patch_cnt <= r_patch_cnt + 16'd1;
                    end else begin
                        r_filter_idx <= r_filter_idx + FILTER_ADDR_WIDTH'(1);
                        r_b_addr     <= r_b_addr + FILTER_ADDR_WIDTH'(1);
                        r_base       <= r_base + WADDR_WIDTH'(TAPS);
                        r_w_addr     <= r_base + WADDR_WIDTH'(TAPS);
                    end
                end
                default: begin
                    r_step <= 4'd0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_kw
        assign bus.kw_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_taps[g];
    end

    assign bus.win_ready  = w_ready;
    assign bus.win_latch  = w_accept;
    assign bus.w_addr     = r_w_addr;
    assign bus.b_addr     = r_b_addr;
    assign bus.core_valid = w_fire;
    assign bus.filter_idx = r_filter_idx;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.patch_done = w_fire & w_last;
    assign bus.patch_cnt  = r_patch_cnt;
endmodule

// File: tb/tb_conv_filter_sched.sv
// Scoreboard bench: three schedulers (32 filters L=1, 32 filters L=3, 1 filter L=1)
// fed by ROM models returning addr[7:0]; expected fires are queued at each accept.
module tb_conv_filter_sched;
    localparam int NF_A  [3] = '{32, 32, 1};
    localparam int LAT_A [3] = '{1, 3, 1};

    typedef struct {
        int          cyc;
        int          f;
        logic [71:0] kw;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  valid = 3'b000;
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          busy_end [3] = '{-1, -1, -1};
    bit          exp_busy [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] mcnt [3] = '{16'd0, 16'd0, 16'd0};
    exp_t        sb [3][$];

    logic [7:0]  q0;
    logic [7:0]  q1_p0, q1_p1, q1_p2;
    logic [7:0]  q2;

    conv_filter_sched_if #(.DATA_WIDTH(8), .WADDR_WIDTH(9), .FILTER_ADDR_WIDTH(5)) if0 ();
    conv_filter_sched_if #(.DATA_WIDTH(8), .WADDR_WIDTH(9), .FILTER_ADDR_WIDTH(5)) if1 ();
    conv_filter_sched_if #(.DATA_WIDTH(8), .WADDR_WIDTH(9), .FILTER_ADDR_WIDTH(1)) if2 ();

    conv_filter_sched #(.DATA_WIDTH(8), .NUM_FILTERS(32), .TAPS(9), .WADDR_WIDTH(9),
                        .FILTER_ADDR_WIDTH(5), .ROM_LATENCY(1))
        u_dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    conv_filter_sched #(.DATA_WIDTH(8), .NUM_FILTERS(32), .TAPS(9), .WADDR_WIDTH(9),
                        .FILTER_ADDR_WIDTH(5), .ROM_LATENCY(3))
        u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    conv_filter_sched #(.DATA_WIDTH(8), .NUM_FILTERS(1), .TAPS(9), .WADDR_WIDTH(9),
                        .FILTER_ADDR_WIDTH(1), .ROM_LATENCY(1))
        u_dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        q0    <= if0.w_addr[7:0];
        q1_p0 <= if1.w_addr[7:0];
        q1_p1 <= q1_p0;
        q1_p2 <= q1_p1;
        q2    <= if2.w_addr[7:0];
    end

    assign if0.w_q = q0;
    assign if1.w_q = q1_p2;
    assign if2.w_q = q2;
    assign if0.win_valid = valid[0];
    assign if1.win_valid = valid[1];
    assign if2.win_valid = valid[2];

    task automatic chk(input string tag, input int d, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s dut%0d cyc%0d: got %0h expected %0h", tag, d, cyc, got, exp);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic lat, input logic rdy,
                       input logic cv, input logic pd, input logic bsy,
                       input logic [31:0] fidx, input logic [31:0] baddr,
                       input logic [71:0] kw, input logic [15:0] pcnt);
        logic exp_rdy;
        logic exp_lat;
        logic exp_fire;
        exp_t e;
        exp_rdy  = !rst && (cyc > busy_end[d]);
        exp_lat  = v && exp_rdy;
        exp_fire = (sb[d].size() > 0) && (sb[d][0].cyc == cyc);
        chk("win_ready", d, 72'(rdy), 72'(exp_rdy));
        chk("win_latch", d, 72'(lat), 72'(exp_lat));
        chk("core_valid", d, 72'(cv), 72'(exp_fire));
        chk("busy", d, 72'(bsy), 72'(exp_busy[d]));
        chk("patch_cnt", d, 72'(pcnt), 72'(mcnt[d]));
        if (exp_fire) begin
            e = sb[d].pop_front();
            chk("filter_idx", d, 72'(fidx), 72'(e.f));
            chk("b_addr", d, 72'(baddr), 72'(e.f));
            chk("kw_flat", d, kw, e.kw);
            chk("patch_done", d, 72'(pd), 72'(e.last));
            if (e.last) begin
                mcnt[d]     = mcnt[d] + 16'd1;
                exp_busy[d] = 1'b0;
            end
        end else begin
            chk("patch_done_idle", d, 72'(pd), 72'd0);
        end
        if (exp_lat) begin
            for (int f = 0; f < NF_A[d]; f++) begin
                e.cyc  = cyc + (10 + LAT_A[d]) * (f + 1);
                e.f    = f;
                e.last = (f == NF_A[d] - 1);
                for (int i = 0; i < 9; i++) begin
                    e.kw[i*8 +: 8] = 8'(9 * f + i);
                end
                sb[d].push_back(e);
            end
            busy_end[d] = cyc + NF_A[d] * (10 + LAT_A[d]);
            exp_busy[d] = 1'b1;
        end
        if (rst) begin
            sb[d].delete();
            busy_end[d] = cyc;
            exp_busy[d] = 1'b0;
            mcnt[d]     = 16'd0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, if0.win_valid, if0.win_latch, if0.win_ready, if0.core_valid, if0.patch_done,
                if0.busy, 32'(if0.filter_idx), 32'(if0.b_addr), if0.kw_flat, if0.patch_cnt);
            mon(1, if1.win_valid, if1.win_latch, if1.win_ready, if1.core_valid, if1.patch_done,
                if1.busy, 32'(if1.filter_idx), 32'(if1.b_addr), if1.kw_flat, if1.patch_cnt);
            mon(2, if2.win_valid, if2.win_latch, if2.win_ready, if2.core_valid, if2.patch_done,
                if2.busy, 32'(if2.filter_idx), 32'(if2.b_addr), if2.kw_flat, if2.patch_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and check the cleared register state
        tick(1);
        mon_en = 1'b1;
        tick(2);
        chk("rst_w_addr", 0, 72'(if0.w_addr), 72'd0);
        chk("rst_b_addr", 0, 72'(if0.b_addr), 72'd0);
        chk("rst_filter_idx", 0, 72'(if0.filter_idx), 72'd0);
        chk("rst_kw_flat", 0, if0.kw_flat, 72'd0);
        chk("rst_w_addr_l3", 1, 72'(if1.w_addr), 72'd0);
        rst = 1'b0;
        tick(2);

        // One patch on every instance, then stray valid pulses while dut0 is busy
        valid = 3'b111;
        tick(1);
        valid = 3'b000;
        tick(20);
        valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(12);
        valid[0] = 1'b1;
        tick(3);
        valid[0] = 1'b0;
        tick(500);

        // Continuous valid: back-to-back patches
        valid[0] = 1'b1;
        valid[2] = 1'b1;
        tick(1054);
        valid = 3'b000;
        tick(400);

        // Reset fifty cycles into a patch, then restart
        valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(49);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_w_addr", 0, 72'(if0.w_addr), 72'd0);
        chk("midrst_busy", 0, 72'(if0.busy), 72'd0);
        tick(30);
        valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(400);

        for (int d = 0; d < 3; d++) begin
            chk("pending_fires", d, 72'(sb[d].size()), 72'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
